// File: rtl/burst_addr_arbiter_pkg.sv
// Shared types and constants for the burst address arbiter slice.
// Optional feature macro used by this slice: BURST_ABORT_EN.
package burst_addr_arbiter_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned LEN_W  = 6;

  // Requester indices into req/gnt.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  // Round-robin pick: a lone requester wins; on a tie the requester
  // that was not granted last wins. Result is the winner's index.
  function automatic logic rr_pick(input logic [1:0] req, input logic lp);
    if (req[REQ0] && req[REQ1]) begin
      return ~lp;
    end
    return req[REQ1];
  endfunction

endpackage

// File: rtl/burst_addr_arbiter_if.sv
// Requester/memory-side bundle for burst_addr_arbiter.
// The abort signal exists only when BURST_ABORT_EN is defined.
interface burst_addr_arbiter_if;
  import burst_addr_arbiter_pkg::*;

  logic [1:0]        req;
  logic [ADDR_W-1:0] base0;
  logic [LEN_W-1:0]  len0;
  logic [ADDR_W-1:0] base1;
  logic [LEN_W-1:0]  len1;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              done;
`ifdef BURST_ABORT_EN
  logic              abort;
`endif

  // Requester side: drives requests and burst descriptors.
  modport master (
    output req, base0, len0, base1, len1,
`ifdef BURST_ABORT_EN
    output abort,
`endif
    input  gnt, addr, addr_valid, done
  );

  // Arbiter side.
  modport slave (
    input  req, base0, len0, base1, len1,
`ifdef BURST_ABORT_EN
    input  abort,
`endif
    output gnt, addr, addr_valid, done
  );

endinterface

// File: rtl/addr_step6.sv
// 6-bit register with synchronous load and single-step count.
// Load has priority over inc; DOWN selects decrement instead of increment.
module addr_step6
  import burst_addr_arbiter_pkg::*;
#(
  parameter logic DOWN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] value,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] q
);

  // Load wins over step; arithmetic wraps modulo 64.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= value;
    end else if (inc) begin
      if (DOWN) begin
        q <= q - 1'b1;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_addr_arbiter.sv
// Round-robin burst address sequencer for the 64-word buffer.
// Grants one of two requesters, then walks addr from base for len+1 beats.
// Optional feature macro: BURST_ABORT_EN (adds an abort input on the bus).
module burst_addr_arbiter
  import burst_addr_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  burst_addr_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_nx;
  logic              lp;
  logic              win;
  logic              any_req;
  logic              last;
  logic              abort_req;
  logic              ld;
  logic              step;
  logic [ADDR_W-1:0] ld_addr;
  logic [LEN_W-1:0]  ld_len;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic [1:0]        gnt_q;
  logic [1:0]        gnt_d;
  logic              valid_q;
  logic              valid_d;
  logic              done_q;
  logic              done_d;

`ifdef BURST_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign any_req = |bus.req;
  assign win     = rr_pick(bus.req, lp);
  assign last    = (remaining == '0);
  assign ld_addr = win ? bus.base1 : bus.base0;
  assign ld_len  = win ? bus.len1  : bus.len0;

  // State register and last-grant pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lp    <= REQ1;
    end else begin
      state <= state_nx;
      if (ld) begin
        lp <= win;
      end
    end
  end

  // Next-state logic; abort is only honoured while a burst is running.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BURST;
      BURST:   if (last || abort_req) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output/datapath controls: next values for the registered outputs
  // plus load/step strobes for the address and remaining counters.
  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ld      = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          ld      = 1'b1;
          valid_d = 1'b1;
          gnt_d   = win ? 2'b10 : 2'b01;
        end
      end
      BURST: begin
        if (last || abort_req) begin
          done_d = 1'b1;
        end else begin
          step    = 1'b1;
          valid_d = 1'b1;
          gnt_d   = gnt_q;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  addr_step6 #(.DOWN(1'b0)) u_addr (
    .clk   (clk),
    .reset (reset),
    .value (ld_addr),
    .load  (ld),
    .inc   (step),
    .q     (addr_q)
  );

  addr_step6 #(.DOWN(1'b1)) u_remaining (
    .clk   (clk),
    .reset (reset),
    .value (ld_len),
    .load  (ld),
    .inc   (step),
    .q     (remaining)
  );

  assign bus.gnt        = gnt_q;
  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.done       = done_q;

endmodule
